fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, width of program counter and target.
REQ-002 SHALL have parameter INSTR_SIZE, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC loaded at reset.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse that begins fetching from IDLE.
REQ-007 SHALL have port pc_o  output  PC_SIZE  fetch address to instruction memory, equal to internal PC register.
REQ-008 SHALL have port instr_i  input  INSTR_SIZE  combinational instruction returned for pc_o in the same cycle.
REQ-009 SHALL have port done_i  input  1  memory reports no instruction at pc_o (end of program).
REQ-010 SHALL have port redirect_i  input  1  branch/jump redirect request.
REQ-011 SHALL have port target_i  input  PC_SIZE  redirect address.
REQ-012 SHALL have port instr_o  output  INSTR_SIZE  buffered instruction to decode.
REQ-013 SHALL have port instr_pc_o  output  PC_SIZE  address of instr_o.
REQ-014 SHALL have port valid_o  output  1  instr_o/instr_pc_o valid.
REQ-015 SHALL have port ready_i  input  1  decode accepts; transfer when valid_o && ready_i.
REQ-016 SHALL have port halted_o  output  1  high in HALT state.
REQ-017 SHALL have port fetch_count_o  output  32  count of instructions loaded into buffer.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, HALT.
REQ-019 IDLE: no fetch; start_i -> FETCH next cycle; start_i in any other state SHALL be ignored.
REQ-020 Buffer is one entry; "slot free" SHALL mean !valid_o || ready_i.
REQ-021 FETCH, slot free, !done_i, !redirect_i: SHALL load instr_o<=instr_i, instr_pc_o<=pc, valid_o<=1, pc<=pc+4, fetch_count_o+=1; latency pc_o to valid_o = 1 cycle.
REQ-022 FETCH, slot not free: SHALL hold pc, buffer and count unchanged (stall).
REQ-023 FETCH, done_i, !redirect_i: SHALL not load; pc held; if valid_o clears this cycle (or already 0) -> HALT, else -> DRAIN.
REQ-024 Transfer with no new load SHALL clear valid_o next cycle.
REQ-025 DRAIN: no fetch; when !valid_o or transfer occurs -> HALT with valid_o<=0.
REQ-026 HALT: halted_o=1, valid_o=0, pc held; exit only via redirect_i or rst_i.
REQ-027 redirect_i in FETCH/DRAIN/HALT SHALL: pc<={target_i[PC_SIZE-1:2],2'b00}, valid_o<=0 (flush), no load that cycle, next state FETCH.
REQ-028 redirect_i in IDLE SHALL update pc as REQ-027 and remain IDLE.
REQ-029 redirect_i coincident with valid_o && ready_i: transfer SHALL count as accepted by decode; buffer still flushed.
REQ-030 redirect_i SHALL take priority over done_i, start_i and fetch load.
REQ-031 pc+4 SHALL wrap modulo 2^PC_SIZE; fetch_count_o SHALL wrap modulo 2^32.
REQ-032 halted_o SHALL be registered state decode; no output SHALL depend combinationally on ready_i except pc_o (none).

Reset
REQ-033 rst_i high at rising edge SHALL force: state IDLE, pc=RESET_PC, valid_o=0, instr_o=0, instr_pc_o=0, halted_o=0, fetch_count_o=0.
REQ-034 rst_i SHALL override all other inputs, including mid-FETCH or DRAIN, discarding buffered instruction.

Verification
REQ-035 Reset, start_i pulse, ready_i=1, memory words 0x00500093,0x00108113 at 0,4 then done_i at 8 -> valid_o on cycles 1,2 with instr_pc_o 0,4; HALT at cycle 3, fetch_count_o=2.
REQ-036 ready_i=0 for 3 cycles after first load -> instr_o/instr_pc_o=0 stable, pc_o=4 held, fetch_count_o=1; ready_i=1 resumes with pc 4.
REQ-037 Redirect target_i=0x0000_0102 while valid_o=1, ready_i=0 -> next cycle valid_o=0, pc_o=0x100; following load instr_pc_o=0x100.
REQ-038 done_i with valid_o=1, ready_i=0 -> DRAIN, halted_o=0; ready_i=1 -> HALT next cycle, halted_o=1; redirect_i to 0x10 -> FETCH, halted_o=0.
REQ-039 PC_SIZE=32, redirect to 0xFFFF_FFFC, load -> pc_o=0x0000_0000 next cycle.
REQ-040 rst_i asserted during FETCH with valid_o=1 -> next cycle IDLE, valid_o=0, pc_o=RESET_PC, fetch_count_o=0; start_i while FETCH ignored.

Source files
------------

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Purpose:
//   Instruction fetch front end. It walks a program counter through
//   instruction memory, which answers combinationally. Each fetched word goes
//   into a one-entry buffer that decode drains with a valid/ready handshake.
//   The block handles stall, end-of-program drain/halt and branch redirects.
//
// Ports:
//   clk_i          in   1           clock; all state changes on the rising edge
//   rst_i          in   1           synchronous active-high reset
//   start_i        in   1           pulse that leaves IDLE and begins fetching
//   pc_o           out  PC_SIZE     fetch address (the PC register)
//   instr_i        in   INSTR_SIZE  memory word for pc_o, in the same cycle
//   done_i         in   1           no instruction at pc_o (end of program)
//   redirect_i     in   1           branch/jump redirect request
//   target_i       in   PC_SIZE     redirect address (forced word aligned)
//   instr_o        out  INSTR_SIZE  buffered instruction for decode
//   instr_pc_o     out  PC_SIZE     address of instr_o
//   valid_o        out  1           buffer holds a valid instruction
//   ready_i        in   1           decode accepts (transfer = valid_o && ready_i)
//   halted_o       out  1           controller is in HALT
//   fetch_count_o  out  32          number of loads into the buffer (wraps)
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter int                  PC_SIZE    = 32,
    parameter int                  INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [PC_SIZE-1:0]    pc_o,
    input  logic [INSTR_SIZE-1:0] instr_i,
    input  logic                  done_i,
    input  logic                  redirect_i,
    input  logic [PC_SIZE-1:0]    target_i,
    output logic [INSTR_SIZE-1:0] instr_o,
    output logic [PC_SIZE-1:0]    instr_pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  halted_o,
    output logic [31:0]           fetch_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [PC_SIZE-1:0]      r_pc;
    logic [INSTR_SIZE-1:0]   r_instr;
    logic [PC_SIZE-1:0]      r_instr_pc;
    logic                    r_valid;
    logic [31:0]             r_count;

    state_t                  w_state_next;
    logic [PC_SIZE-1:0]      w_pc_next;
    logic [INSTR_SIZE-1:0]   w_instr_next;
    logic [PC_SIZE-1:0]      w_instr_pc_next;
    logic                    w_valid_next;
    logic [31:0]             w_count_next;

    logic                    w_slot_free;
    logic                    w_xfer;
    logic [PC_SIZE-1:0]      w_redir_pc;
    logic                    w_unused_bits;

    assign w_slot_free = !r_valid || ready_i;
    assign w_xfer      = r_valid && ready_i;
    // Redirect targets are forced onto a word boundary; the low bits are dropped.
    assign w_redir_pc  = {target_i[PC_SIZE-1:2], 2'b00};
    assign w_unused_bits = ^target_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
            r_valid    <= w_valid_next;
            r_count    <= w_count_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
        // A transfer with no new load empties the buffer.
        w_valid_next    = r_valid && !ready_i;
        w_count_next    = r_count;

        if (redirect_i && (r_state != S_IDLE)) begin
            // Redirect wins over done, start and any load: flush and refetch.
            // A coincident transfer has already been taken by decode.
            w_pc_next    = w_redir_pc;
            w_valid_next = 1'b0;
            w_state_next = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_valid_next = 1'b0;
                    if (redirect_i) begin
                        w_pc_next = w_redir_pc;
                    end else if (start_i) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (done_i) begin
                        // No load. If the buffer is empty after this cycle
                        // there is nothing left to drain.
                        w_state_next = w_valid_next ? S_DRAIN : S_HALT;
                    end else if (w_slot_free) begin
                        w_instr_next    = instr_i;
                        w_instr_pc_next = r_pc;
                        w_valid_next    = 1'b1;
                        w_pc_next       = r_pc + PC_SIZE'(4);
                        w_count_next    = r_count + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (!r_valid || w_xfer) begin
                        w_state_next = S_HALT;
                        w_valid_next = 1'b0;
                    end
                end
                S_HALT: begin
                    w_valid_next = 1'b0;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign valid_o       = r_valid;
    assign halted_o      = (r_state == S_HALT);
    assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed scenarios followed by random traffic. A behavioural model of the
// fetch front end predicts every output after each clock edge. Every word
// that decode accepts must also match the memory contents at its address.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, done_i, redirect_i, ready_i;
    logic [31:0] pc_o, instr_i, target_i, instr_o, instr_pc_o, fetch_count_o;
    logic        valid_o, halted_o;

    int checks = 0;
    int errors = 0;

    fetch_controller #(.PC_SIZE(32), .INSTR_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_o(pc_o),
        .instr_i(instr_i), .done_i(done_i), .redirect_i(redirect_i),
        .target_i(target_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .valid_o(valid_o), .ready_i(ready_i), .halted_o(halted_o),
        .fetch_count_o(fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: two fixed words at 0 and 4, a hash everywhere else.
    function automatic logic [31:0] mword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_8113;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
    endfunction

    assign instr_i = mword(pc_o);

    // Model state: where fetching is, and what the one-entry buffer holds.
    typedef enum int {M_IDLE, M_RUN, M_WAIT_EMPTY, M_STOPPED} mmode_t;
    mmode_t      m_mode;
    logic [31:0] m_pc, m_instr, m_ipc, m_count;
    logic        m_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rd,
                        input logic [31:0] tg, input logic rdy, input logic dn);
        logic taken;
        logic keep;
        rst_i = rst; start_i = st; redirect_i = rd; target_i = tg;
        ready_i = rdy; done_i = dn;
        #1;
        // Anything decode takes must be the memory word at its address.
        if (!rst && valid_o === 1'b1 && rdy) chk("accepted_word", instr_o, mword(instr_pc_o));

        taken = m_valid && rdy;
        keep  = m_valid && !taken;
        if (rst) begin
            m_mode = M_IDLE; m_pc = 32'h0; m_valid = 1'b0;
            m_instr = 32'h0; m_ipc = 32'h0; m_count = 32'h0;
        end else if (rd) begin
            m_pc = tg & 32'hFFFF_FFFC;
            if (m_mode != M_IDLE) begin
                m_valid = 1'b0;
                m_mode  = M_RUN;
            end
        end else begin
            case (m_mode)
                M_IDLE: if (st) m_mode = M_RUN;
                M_RUN: begin
                    if (dn) begin
                        m_valid = keep;
                        m_mode  = keep ? M_WAIT_EMPTY : M_STOPPED;
                    end else if (!m_valid || rdy) begin
                        m_instr = mword(m_pc);
                        m_ipc   = m_pc;
                        m_valid = 1'b1;
                        m_pc    = m_pc + 32'd4;
                        m_count = m_count + 32'd1;
                    end
                end
                M_WAIT_EMPTY: begin
                    m_valid = keep;
                    if (!keep) m_mode = M_STOPPED;
                end
                default: m_valid = 1'b0;
            endcase
        end

        @(posedge clk_i);
        #1;
        chk("pc_o", pc_o, m_pc);
        chk("valid_o", valid_o, m_valid);
        chk("instr_o", instr_o, m_instr);
        chk("instr_pc_o", instr_pc_o, m_ipc);
        chk("halted_o", halted_o, m_mode == M_STOPPED);
        chk("fetch_count_o", fetch_count_o, m_count);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; done_i = 1'b0; redirect_i = 1'b0;
        ready_i = 1'b0; target_i = 32'h0;
        @(negedge clk_i);

        // Reset state, then a two-instruction program ending at address 8.
        step(1, 0, 0, 0, 1, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_count", fetch_count_o, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("prog_first_pc", instr_pc_o, 32'h0);
        chk("prog_first_word", instr_o, 32'h0050_0093);
        step(0, 0, 0, 0, 1, 0);
        chk("prog_second_pc", instr_pc_o, 32'h4);
        step(0, 0, 0, 0, 1, 1);
        chk("prog_halted", halted_o, 1);
        chk("prog_count", fetch_count_o, 2);

        // Decode stall for three cycles after the first load.
        step(1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("stall_ipc", instr_pc_o, 32'h0);
            chk("stall_pc", pc_o, 32'h4);
            chk("stall_count", fetch_count_o, 1);
        end
        step(0, 0, 0, 0, 1, 0);
        chk("resume_ipc", instr_pc_o, 32'h4);

        // Redirect to an unaligned target while the buffer is held.
        step(0, 0, 1, 32'h0000_0102, 0, 0);
        chk("redir_valid", valid_o, 0);
        chk("redir_pc", pc_o, 32'h100);
        step(0, 0, 0, 0, 1, 0);
        chk("redir_load_ipc", instr_pc_o, 32'h100);

        // End of program with a held buffer drains, halts, then redirects out.
        step(0, 0, 0, 0, 0, 1);
        chk("drain_not_halted", halted_o, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("drain_halted", halted_o, 1);
        step(0, 0, 1, 32'h10, 0, 0);
        chk("halt_exit", halted_o, 0);
        chk("halt_exit_pc", pc_o, 32'h10);

        // PC wraps past the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("wrap_pc", pc_o, 32'h0);

        // Start while fetching is ignored; reset discards the buffer.
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_count", fetch_count_o, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("idle_no_fetch", valid_o, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 97) == 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
                 $urandom, ($urandom % 10) < 7, ($urandom % 12) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
